// File: rtl/dfa_stream_ctx_mgr.sv
// dfa_stream_ctx_mgr: per-stream DFA context save/restore and match counting.
// Sits between the packet parser and a single DFA instance. Each packet
// restores the DFA state of its stream and scans the payload. At end of packet
// the final state and the match flag are committed to per-stream memories.
module dfa_stream_ctx_mgr #(
    parameter int unsigned NUM_STREAMS = 64,
    parameter int unsigned SID_W       = 6,
    parameter int unsigned STATE_W     = 11,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned DFA_LAT     = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pkt_start,
    input  logic [SID_W-1:0]   stream_id,
    input  logic               new_stream,
    input  logic               enable,
    input  logic [7:0]         char_in,
    input  logic               char_in_vld,
    input  logic               eop,
    output logic [7:0]         dfa_char,
    output logic               dfa_char_vld,
    output logic [STATE_W-1:0] dfa_state_in,
    output logic               dfa_state_ld,
    input  logic [STATE_W-1:0] dfa_state_out,
    input  logic               dfa_accept,
    input  logic [SID_W-1:0]   rd_sid,
    output logic [CNT_W-1:0]   rd_count,
    output logic [CNT_W-1:0]   total_count,
    output logic               fired,
    output logic               busy,
    output logic               err_proto
);

    // DRAIN lasts long enough for the last char's accept to reach the fired flag
    localparam int unsigned DRAIN_CYC = DFA_LAT + 2;
    localparam int unsigned DCNT_W    = $clog2(DRAIN_CYC + 1);
    localparam logic [DCNT_W-1:0] DRAIN_LAST = DCNT_W'(DRAIN_CYC - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX    = '1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_RUN    = 3'd2,
        S_DRAIN  = 3'd3,
        S_COMMIT = 3'd4
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [SID_W-1:0]   sid_q;
    logic               en_q;
    logic [STATE_W-1:0] cap_state;
    logic [DCNT_W-1:0]  drain_cnt;
    logic [DFA_LAT-1:0] vld_pipe;
    logic               acc_q;

    logic [STATE_W-1:0] state_mem [NUM_STREAMS];
    logic [CNT_W-1:0]   count_mem [NUM_STREAMS];
    logic [NUM_STREAMS-1:0] ctx_valid;

    logic               proto_err_c;
    logic               start_c;
    logic               res_vld_c;
    logic               commit_c;
    logic               count_inc_c;
    logic [STATE_W-1:0] ctx_c;

    // Packet start acceptance, DFA result timing and commit qualifiers
    always_comb begin
        start_c     = (state == S_IDLE) && pkt_start;
        res_vld_c   = vld_pipe[DFA_LAT-1];
        commit_c    = (state == S_COMMIT) && en_q;
        count_inc_c = commit_c && fired;
        ctx_c       = '0;
        if (!new_stream && ctx_valid[stream_id]) begin
            ctx_c = state_mem[stream_id];
        end
    end

    // Next-state logic and protocol error detection
    always_comb begin
        state_nxt   = state;
        proto_err_c = 1'b0;
        case (state)
            S_IDLE:   if (pkt_start) state_nxt = S_LOAD;
            S_LOAD:   state_nxt = S_RUN;
            S_RUN:    if (eop) state_nxt = S_DRAIN;
            S_DRAIN:  if (drain_cnt == DRAIN_LAST) state_nxt = S_COMMIT;
            S_COMMIT: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
        if (pkt_start && (state != S_IDLE)) begin
            proto_err_c = 1'b1;
        end
        if (eop && (state != S_RUN)) begin
            proto_err_c = 1'b1;
        end
    end

    // FSM state register and status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            busy         <= 1'b0;
            dfa_state_ld <= 1'b0;
            err_proto    <= 1'b0;
            drain_cnt    <= '0;
        end else begin
            state        <= state_nxt;
            busy         <= (state_nxt != S_IDLE);
            dfa_state_ld <= (state_nxt == S_LOAD);
            err_proto    <= err_proto | proto_err_c;
            if (state == S_DRAIN) begin
                drain_cnt <= drain_cnt + DCNT_W'(1);
            end else begin
                drain_cnt <= '0;
            end
        end
    end

    // Latch packet attributes and the restored context at packet start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sid_q        <= '0;
            en_q         <= 1'b0;
            dfa_state_in <= '0;
        end else if (start_c) begin
            sid_q        <= stream_id;
            en_q         <= enable;
            dfa_state_in <= ctx_c;
        end
    end

    // Char path to the DFA; chars outside RUN are dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dfa_char     <= '0;
            dfa_char_vld <= 1'b0;
        end else begin
            dfa_char_vld <= (state == S_RUN) && char_in_vld;
            if ((state == S_RUN) && char_in_vld) begin
                dfa_char <= char_in;
            end
        end
    end

    // Track DFA result validity and capture accept/state of each processed char
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe  <= '0;
            acc_q     <= 1'b0;
            cap_state <= '0;
        end else begin
            vld_pipe <= DFA_LAT'({vld_pipe, dfa_char_vld});
            acc_q    <= res_vld_c && dfa_accept;
            if (state == S_LOAD) begin
                cap_state <= dfa_state_in;
            end else if (res_vld_c) begin
                cap_state <= dfa_state_out;
            end
        end
    end

    // Per-packet match flag: cleared on load, sticky while scanning
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fired <= 1'b0;
        end else begin
            case (state)
                S_LOAD:            fired <= 1'b0;
                S_RUN, S_DRAIN:    fired <= fired | acc_q;
                S_COMMIT:          if (!en_q) fired <= 1'b0;
                default:           fired <= fired;
            endcase
        end
    end

    // Saturating total match counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            total_count <= '0;
        end else if (count_inc_c && (total_count != CNT_MAX)) begin
            total_count <= total_count + CNT_W'(1);
        end
    end

    // Per-stream saturating counts, context-valid bits and count read port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_STREAMS; i++) begin
                count_mem[i] <= '0;
            end
            ctx_valid <= '0;
            rd_count  <= '0;
        end else begin
            rd_count <= count_mem[rd_sid];
            if (commit_c) begin
                ctx_valid[sid_q] <= 1'b1;
            end
            if (count_inc_c && (count_mem[sid_q] != CNT_MAX)) begin
                count_mem[sid_q] <= count_mem[sid_q] + CNT_W'(1);
            end
        end
    end

    // Saved DFA state per stream; only meaningful where ctx_valid is set
    always_ff @(posedge clk) begin
        if (commit_c) begin
            state_mem[sid_q] <= cap_state;
        end
    end

endmodule

// File: tb/tb_dfa_stream_ctx_mgr.sv
// tb_dfa_stream_ctx_mgr: randomized scoreboard bench with a behavioural DFA
// and a per-packet reference model of context save/restore and counting.
module tb_dfa_stream_ctx_mgr;

    localparam int unsigned NS    = 64;
    localparam int unsigned SID_W = 6;
    localparam int unsigned ST_W  = 11;
    localparam int unsigned CNT_W = 6;
    localparam int unsigned CMAX  = 63;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              pkt_start = 1'b0;
    logic [SID_W-1:0]  stream_id = '0;
    logic              new_stream = 1'b0;
    logic              enable = 1'b0;
    logic [7:0]        char_in = '0;
    logic              char_in_vld = 1'b0;
    logic              eop = 1'b0;
    logic [7:0]        dfa_char;
    logic              dfa_char_vld;
    logic [ST_W-1:0]   dfa_state_in;
    logic              dfa_state_ld;
    logic [ST_W-1:0]   dfa_state_out;
    logic              dfa_accept;
    logic [SID_W-1:0]  rd_sid = '0;
    logic [CNT_W-1:0]  rd_count;
    logic [CNT_W-1:0]  total_count;
    logic              fired;
    logic              busy;
    logic              err_proto;

    dfa_stream_ctx_mgr #(
        .NUM_STREAMS(NS), .SID_W(SID_W), .STATE_W(ST_W), .CNT_W(CNT_W), .DFA_LAT(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pkt_start(pkt_start), .stream_id(stream_id),
        .new_stream(new_stream), .enable(enable), .char_in(char_in),
        .char_in_vld(char_in_vld), .eop(eop), .dfa_char(dfa_char),
        .dfa_char_vld(dfa_char_vld), .dfa_state_in(dfa_state_in),
        .dfa_state_ld(dfa_state_ld), .dfa_state_out(dfa_state_out),
        .dfa_accept(dfa_accept), .rd_sid(rd_sid), .rd_count(rd_count),
        .total_count(total_count), .fired(fired), .busy(busy), .err_proto(err_proto)
    );

    initial forever #5 clk = ~clk;

    // Behavioural DFA: 1-cycle latency, accepts right after consuming '/'
    function automatic logic [ST_W-1:0] nxt(input logic [ST_W-1:0] s, input logic [7:0] c);
        return ST_W'((s * 11'd5) + {3'b000, c} + 11'd1);
    endfunction

    logic [ST_W-1:0] dst = '0;
    logic            dacc = 1'b0;
    always @(posedge clk) begin
        if (dfa_state_ld) begin
            dst <= dfa_state_in;
        end else if (dfa_char_vld) begin
            dst  <= nxt(dst, dfa_char);
            dacc <= (dfa_char == 8'h2F);
        end
    end
    assign dfa_state_out = dst;
    assign dfa_accept    = dacc;

    // Reference model state
    int unsigned     m_cnt   [NS];
    logic [ST_W-1:0] m_smem  [NS];
    bit              m_valid [NS];
    int unsigned     m_total;
    bit              m_err;

    typedef struct packed {
        logic             fired;
        logic [CNT_W-1:0] total;
        logic             err;
    } done_t;

    logic [ST_W-1:0]  ld_q [$];
    done_t            done_q [$];
    logic [CNT_W-1:0] rd_q [$];
    logic [7:0]       pchars [$];

    int  n_tests = 0;
    int  n_fail  = 0;
    logic rd_req = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NS; i++) begin
            m_cnt[i]   = 0;
            m_valid[i] = 1'b0;
            m_smem[i]  = '0;
        end
        m_total = 0;
        m_err   = 1'b0;
    endtask

    // Monitor: compares DUT outputs against queued expectations
    bit    prev_busy = 1'b0;
    bit    rd_pend   = 1'b0;
    always @(negedge clk) begin
        logic [ST_W-1:0]  e_ctx;
        logic [CNT_W-1:0] e_rd;
        done_t            e_d;
        if (!rst_n) begin
            prev_busy = 1'b0;
            rd_pend   = 1'b0;
        end else begin
            if (dfa_state_ld) begin
                if (ld_q.size() == 0) begin
                    check("unexpected_load", 32'd1, 32'd0);
                end else begin
                    e_ctx = ld_q.pop_front();
                    check("ctx_load", 32'(dfa_state_in), 32'(e_ctx));
                end
            end
            if (prev_busy && !busy) begin
                if (done_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e_d = done_q.pop_front();
                    check("fired", 32'(fired), 32'(e_d.fired));
                    check("total_count", 32'(total_count), 32'(e_d.total));
                    check("err_proto", 32'(err_proto), 32'(e_d.err));
                end
            end
            if (rd_pend) begin
                if (rd_q.size() == 0) begin
                    check("unexpected_read", 32'd1, 32'd0);
                end else begin
                    e_rd = rd_q.pop_front();
                    check("rd_count", 32'(rd_count), 32'(e_rd));
                end
            end
            prev_busy = busy;
            rd_pend   = rd_req;
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 60) begin
            step();
            n++;
        end
        if (busy) check("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic read_cnt(input int sid);
        rd_sid = SID_W'(sid);
        rd_req = 1'b1;
        rd_q.push_back(CNT_W'(m_cnt[sid]));
        step();
        rd_req = 1'b0;
    endtask

    // Drive one packet from pchars; model the expected outcome at a packet level
    task automatic send_pkt(input int sid, input bit nw, input bit en, input bit inj_start,
                            input bit push_done, input bit commit_read);
        logic [ST_W-1:0] ctx;
        logic [ST_W-1:0] st;
        bit              fr;
        int unsigned     pre;
        done_t           d;
        ctx = (nw || !m_valid[sid]) ? '0 : m_smem[sid];
        ld_q.push_back(ctx);
        pkt_start = 1'b1; stream_id = SID_W'(sid); new_stream = nw; enable = en;
        char_in_vld = 1'b0; eop = 1'b0;
        step();
        // LOAD cycle: garbage on the sampled inputs and a stray '/' must be ignored
        pkt_start = 1'b0; stream_id = SID_W'($urandom); new_stream = 1'($urandom);
        enable = 1'($urandom); char_in = 8'h2F; char_in_vld = 1'b1;
        step();
        char_in_vld = 1'b0;
        st = ctx;
        fr = 1'b0;
        if (pchars.size() == 0) begin
            eop = 1'b1;
            step();
        end else begin
            for (int i = 0; i < pchars.size(); i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    char_in = 8'h2F; char_in_vld = 1'b0;
                    step();
                end
                char_in = pchars[i]; char_in_vld = 1'b1; eop = (i == pchars.size() - 1);
                if (inj_start && i == 0) begin
                    pkt_start = 1'b1; stream_id = SID_W'(sid + 1); m_err = 1'b1;
                end
                st = nxt(st, pchars[i]);
                if (pchars[i] == 8'h2F) fr = 1'b1;
                step();
                pkt_start = 1'b0;
            end
        end
        char_in_vld = 1'b0; eop = 1'b0;
        pre = m_cnt[sid];
        if (en) begin
            m_smem[sid]  = st;
            m_valid[sid] = 1'b1;
            if (fr) begin
                if (m_cnt[sid] < CMAX) m_cnt[sid]++;
                if (m_total < CMAX) m_total++;
            end
        end
        d.fired = en & fr;
        d.total = CNT_W'(m_total);
        d.err   = m_err;
        if (push_done) done_q.push_back(d);
        if (commit_read) begin
            // this read lands in the COMMIT cycle and must see the old count
            step(); step(); step();
            rd_sid = SID_W'(sid); rd_req = 1'b1;
            rd_q.push_back(CNT_W'(pre));
            step();
            rd_req = 1'b0;
        end
    endtask

    task automatic rand_chars(input int n);
        logic [7:0] alpha [5];
        alpha[0] = 8'h61; alpha[1] = 8'h47; alpha[2] = 8'h2F; alpha[3] = 8'h54; alpha[4] = 8'h20;
        pchars.delete();
        for (int i = 0; i < n; i++) pchars.push_back(alpha[$urandom_range(0, 4)]);
    endtask

    initial begin
        model_reset();
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_fired", 32'(fired), 32'd0);
        check("rst_total", 32'(total_count), 32'd0);
        check("rst_err", 32'(err_proto), 32'd0);
        check("rst_ld", 32'(dfa_state_ld), 32'd0);
        check("rst_char_vld", 32'(dfa_char_vld), 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // "GET /" on new stream 3 -> one match
        pchars = '{8'h47, 8'h45, 8'h54, 8'h20, 8'h2F};
        send_pkt(3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        wait_idle();
        read_cnt(3);
        // continuation restores the saved state
        pchars = '{8'h61, 8'h62};
        send_pkt(3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        wait_idle();
        // disabled packet with a match: no commit, flag cleared
        pchars = '{8'h2F, 8'h61};
        send_pkt(3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        wait_idle();
        read_cnt(3);
        pchars = '{8'h63};
        send_pkt(3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        wait_idle();
        // zero-char packet re-saves state unchanged
        pchars.delete();
        send_pkt(3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        wait_idle();
        pchars = '{8'h64};
        send_pkt(3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        wait_idle();

        // Random interleaved streams
        for (int p = 0; p < 50; p++) begin
            rand_chars($urandom_range(0, 6));
            send_pkt(int'($urandom_range(0, 7)), ($urandom_range(0, 4) == 0),
                     ($urandom_range(0, 3) != 0), 1'b0, 1'b1, ($urandom_range(0, 5) == 0));
            wait_idle();
        end
        for (int s = 0; s < 8; s++) read_cnt(s);

        // eop while idle flags a protocol error
        eop = 1'b1;
        step();
        eop = 1'b0;
        m_err = 1'b1;
        step();
        check("err_eop_idle", 32'(err_proto), 32'd1);

        // Reset in DRAIN: immediate idle, counts cleared, no commit
        pchars = '{8'h2F, 8'h61};
        send_pkt(2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_total", 32'(total_count), 32'd0);
        check("mid_rst_err", 32'(err_proto), 32'd0);
        model_reset();
        @(negedge clk);
        step();
        rst_n = 1'b1;
        step();
        read_cnt(2);
        pchars = '{8'h61, 8'h2F};
        send_pkt(2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        wait_idle();
        read_cnt(2);

        // pkt_start in RUN ignored and flagged; match on the eop char counted
        pchars = '{8'h61, 8'h62, 8'h2F};
        send_pkt(4, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        wait_idle();
        read_cnt(4);
        read_cnt(5);

        // Saturate stream 5 and the total
        for (int p = 0; p < 66; p++) begin
            pchars = '{8'h2F};
            send_pkt(5, 1'b0, 1'b1, 1'b0, 1'b1, (p == 65));
            wait_idle();
        end
        read_cnt(5);
        read_cnt(4);
        step();
        step();

        check("ld_q_empty", 32'(ld_q.size()), 32'd0);
        check("done_q_empty", 32'(done_q.size()), 32'd0);
        check("rd_q_empty", 32'(rd_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
